// File: rtl/io_port_responder_pkg.sv
// Shared definitions for the memory-mapped IO port block: default window
// base, register word indices and STATUS bit positions. The processor
// integration imports the same package, so both sides decode the same map.
package io_port_responder_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

    typedef enum logic [2:0] {
        REG_PORT_OUT = 3'd0,
        REG_PORT_IN  = 3'd1,
        REG_STATUS   = 3'd2,
        REG_IRQ_EN   = 3'd3,
        REG_COUNT    = 3'd4,
        REG_COMPARE  = 3'd5,
        REG_CTRL     = 3'd6,
        REG_RSVD     = 3'd7
    } reg_idx_e;

    localparam int ST_IN_CHG    = 0;
    localparam int ST_CMP_MATCH = 1;

endpackage

// File: rtl/io_port_responder_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input bus with a change flag.
// The flag is raised on the cycle whose edge loads a new value into the
// synchronized register, so a sticky status bit set from it becomes
// visible together with the new synchronized value.
module sync_edge_detect #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic             changed
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next-state for the two synchronizer stages.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Synchronizer flops; both clear so a held-low input never looks like a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;
    assign changed  = (sync_d != sync_q);

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped IO responder: an 8-word register window at IO_BASE with an
// output port, a synchronized input port, a free-running compare counter
// and sticky W1C status flags that drive a level interrupt.
module io_port_responder
    import io_port_responder_pkg::*;
#(
    parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
    parameter int          IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         ReadData,
    output logic                Hit,
    output logic [31:0]         PortOut,
    output logic                Irq
);

    logic [31:0]         port_out_q, port_out_d;
    logic [1:0]          status_q, status_d;
    logic [1:0]          irq_en_q, irq_en_d;
    logic [31:0]         count_q, count_d;
    logic [31:0]         compare_q, compare_d;
    logic                ctrl_q, ctrl_d;

    logic [IN_WIDTH-1:0] port_in_sync;
    logic                in_chg;
    reg_idx_e            idx;
    logic                wr_en;
    logic [1:0]          st_set, st_clr;
    logic [31:0]         rd_val;
    logic                unused_addr_bits;

    sync_edge_detect #(.WIDTH(IN_WIDTH)) u_sync (
        .clk      (clk),
        .rst_n    (reset),
        .async_in (PortIn),
        .sync_out (port_in_sync),
        .changed  (in_chg)
    );

    // Byte offset within a word carries no meaning for word registers.
    assign unused_addr_bits = ^Address[1:0];

    assign Hit   = (Address[31:5] == IO_BASE[31:5]);
    assign idx   = reg_idx_e'(Address[4:2]);
    assign wr_en = MemWrite && Hit;
    assign Irq   = |(status_q & irq_en_q);

    // Register next-state: counter advance, status set/clear, and bus writes.
    always_comb begin
        port_out_d = port_out_q;
        irq_en_d   = irq_en_q;
        compare_d  = compare_q;
        ctrl_d     = ctrl_q;
        count_d    = ctrl_q ? count_q + 32'd1 : count_q;
        st_clr     = 2'b00;
        st_set     = 2'b00;
        st_set[ST_IN_CHG]    = in_chg;
        // Match uses the pre-edge count, so a same-cycle COUNT write cannot hide it.
        st_set[ST_CMP_MATCH] = ctrl_q && (count_q == compare_q);
        if (wr_en) begin
            case (idx)
                REG_PORT_OUT: port_out_d = WriteData;
                REG_STATUS:   st_clr     = WriteData[1:0];
                REG_IRQ_EN:   irq_en_d   = WriteData[1:0];
                REG_COUNT:    count_d    = WriteData;
                REG_COMPARE:  compare_d  = WriteData;
                REG_CTRL:     ctrl_d     = WriteData[0];
                default:      ;
            endcase
        end
        // A set event on the same edge as a W1C keeps the flag.
        status_d = (status_q & ~st_clr) | st_set;
    end

    // Architectural state, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_q <= '0;
            status_q   <= '0;
            irq_en_q   <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            ctrl_q     <= 1'b0;
        end else begin
            port_out_q <= port_out_d;
            status_q   <= status_d;
            irq_en_q   <= irq_en_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // Side-effect-free read mux; unused upper bits read as zero.
    always_comb begin
        rd_val = '0;
        case (idx)
            REG_PORT_OUT: rd_val = port_out_q;
            REG_PORT_IN:  rd_val = 32'(port_in_sync);
            REG_STATUS:   rd_val = {30'b0, status_q};
            REG_IRQ_EN:   rd_val = {30'b0, irq_en_q};
            REG_COUNT:    rd_val = count_q;
            REG_COMPARE:  rd_val = compare_q;
            REG_CTRL:     rd_val = {31'b0, ctrl_q};
            default:      rd_val = '0;
        endcase
        ReadData = (MemRead && Hit) ? rd_val : 32'h0;
    end

    assign PortOut = port_out_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: register map, synchronized input
// with change flag, compare counter with wrap, W1C priority, window
// decode and asynchronous reset.
module tb_io_port_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        Irq;

    int n_cmp = 0;
    int n_err = 0;

    io_port_responder #(.IO_BASE(BASE), .IN_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .PortIn    (PortIn),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortOut   (PortOut),
        .Irq       (Irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
        Address   = 32'h0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Address = a;
        MemRead = 1'b1;
        #1;
        check(tag, ReadData, exp);
        MemRead = 1'b0;
        Address = 32'h0;
    endtask

    initial begin
        reset     = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PortIn    = 8'h00;
        #12;
        check("rst_portout", PortOut, 32'h0);
        check("rst_irq", {31'b0, Irq}, 32'h0);
        rd_check("rst_status", BASE + 32'h8, 32'h0);
        rd_check("rst_count", BASE + 32'h10, 32'h0);
        #3;
        reset = 1'b1;
        tick();

        // Output port write and readback (byte offset ignored)
        wr(BASE + 32'h0, 32'hA5A5_0F0F);
        check("portout_wr", PortOut, 32'hA5A5_0F0F);
        rd_check("portout_rd", BASE + 32'h2, 32'hA5A5_0F0F);
        Address = BASE;
        #1;
        check("hit_base", {31'b0, Hit}, 32'h1);
        check("rd_no_memread", ReadData, 32'h0);
        Address = 32'h0;

        // Reserved word and narrow register masking
        wr(BASE + 32'h1C, 32'hFFFF_FFFF);
        rd_check("rsvd_rd", BASE + 32'h1C, 32'h0);
        wr(BASE + 32'hC, 32'hFFFF_FFFF);
        rd_check("irqen_mask", BASE + 32'hC, 32'h3);
        wr(BASE + 32'hC, 32'h0);

        // Synchronized input and change flag
        PortIn = 8'h3C;
        tick();
        rd_check("portin_1cyc", BASE + 32'h4, 32'h0);
        rd_check("status_1cyc", BASE + 32'h8, 32'h0);
        tick();
        rd_check("portin_2cyc", BASE + 32'h4, 32'h3C);
        rd_check("status_chg", BASE + 32'h8, 32'h1);
        check("irq_masked", {31'b0, Irq}, 32'h0);
        wr(BASE + 32'h8, 32'h1);
        rd_check("status_w1c", BASE + 32'h8, 32'h0);

        // W1C on the same edge as a new change: set wins
        PortIn = 8'h55;
        tick();
        wr(BASE + 32'h8, 32'h1);
        rd_check("status_setwins", BASE + 32'h8, 32'h1);
        rd_check("portin_55", BASE + 32'h4, 32'h55);
        wr(BASE + 32'h8, 32'h1);
        rd_check("status_clr2", BASE + 32'h8, 32'h0);

        // Compare match after the 6th edge following enable
        wr(BASE + 32'h14, 32'd5);
        wr(BASE + 32'h10, 32'd0);
        wr(BASE + 32'hC, 32'h2);
        wr(BASE + 32'h18, 32'h1);
        rd_check("ctrl_rd", BASE + 32'h18, 32'h1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("irq_before_match", {31'b0, Irq}, 32'h0);
        end
        rd_check("count_5", BASE + 32'h10, 32'd5);
        tick();
        check("irq_match", {31'b0, Irq}, 32'h1);
        rd_check("status_match", BASE + 32'h8, 32'h2);
        rd_check("count_6", BASE + 32'h10, 32'd6);

        // Count load while enabled, wrap without flag
        wr(BASE + 32'h8, 32'h3);
        wr(BASE + 32'h14, 32'h100);
        wr(BASE + 32'h10, 32'hFFFF_FFFE);
        rd_check("count_load", BASE + 32'h10, 32'hFFFF_FFFE);
        tick();
        rd_check("count_ffff", BASE + 32'h10, 32'hFFFF_FFFF);
        tick();
        rd_check("count_wrap0", BASE + 32'h10, 32'h0);
        tick();
        rd_check("count_wrap1", BASE + 32'h10, 32'h1);
        rd_check("status_nowrapflag", BASE + 32'h8, 32'h0);

        // Out-of-window stores
        Address = BASE + 32'h20;
        #1;
        check("hit_above", {31'b0, Hit}, 32'h0);
        wr(BASE + 32'h20, 32'h1234_5678);
        check("miss_above_portout", PortOut, 32'hA5A5_0F0F);
        Address = BASE - 32'h4;
        #1;
        check("hit_below", {31'b0, Hit}, 32'h0);
        wr(BASE - 32'h4, 32'h0);
        rd_check("miss_below_compare", BASE + 32'h14, 32'h100);
        rd_check("miss_read_zero", BASE + 32'h20, 32'h0);

        // Asynchronous reset mid-count
        PortIn = 8'hAA;
        wr(BASE + 32'hC, 32'h1);
        tick();
        check("irq_inchg", {31'b0, Irq}, 32'h1);
        #2;
        reset  = 1'b0;
        PortIn = 8'h00;
        #1;
        check("arst_portout", PortOut, 32'h0);
        check("arst_irq", {31'b0, Irq}, 32'h0);
        rd_check("arst_count", BASE + 32'h10, 32'h0);
        rd_check("arst_ctrl", BASE + 32'h18, 32'h0);
        rd_check("arst_portin", BASE + 32'h4, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        tick();
        rd_check("post_rst_count", BASE + 32'h10, 32'h0);
        rd_check("post_rst_status", BASE + 32'h8, 32'h0);
        rd_check("post_rst_compare", BASE + 32'h14, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_port_responder.md
IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 Parameter IO_BASE, default 32'hFFFF_0000, byte base address of the 8-word register window.
REQ-002 Parameter IN_WIDTH, default 8, width of PortIn.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Address  input  32  byte address from processor ALU result.
REQ-006 WriteData  input  32  store data.
REQ-007 MemWrite  input  1  store strobe, sampled on the clk edge.
REQ-008 MemRead  input  1  load strobe, qualifies ReadData.
REQ-009 PortIn  input  IN_WIDTH  asynchronous external input pins.
REQ-010 ReadData  output  32  load data, combinational.
REQ-011 Hit  output  1  Address lies inside the window; processor muxes ReadData and suppresses its data-memory write.
REQ-012 PortOut  output  32  registered output port.
REQ-013 Irq  output  1  OR of enabled sticky status flags.

Function
REQ-014 Hit SHALL be 1 iff Address[31:5]==IO_BASE[31:5]; Address[1:0] is ignored; the word index is Address[4:2].
REQ-015 Register map by word index: 0 PORT_OUT (RW), 1 PORT_IN (RO), 2 STATUS (W1C), 3 IRQ_EN (RW, bits[1:0]), 4 COUNT (RW), 5 COMPARE (RW), 6 CTRL (RW, bit0 count enable), 7 reserved (reads 0, writes ignored).
REQ-016 A write SHALL occur only when MemWrite & Hit at a clk edge, and takes effect on that edge.
REQ-017 ReadData SHALL equal the addressed register when MemRead & Hit, else 32'h0; zero-cycle latency, with no read side effects.
REQ-018 PortIn SHALL pass through a 2-flop synchronizer; PORT_IN reads the zero-extended synchronized value, 2-cycle latency.
REQ-019 STATUS bit0 (in_chg) SHALL set on the cycle the synchronized value differs from its previous registered value.
REQ-020 COUNT SHALL increment by 1 per cycle when CTRL.bit0=1 and wrap 32'hFFFF_FFFF→0 with no flag.
REQ-021 STATUS bit1 (cmp_match) SHALL set on the cycle COUNT==COMPARE while counting.
REQ-022 Writing 1 to a STATUS bit clears it; writing 0 leaves it; if a set event and a clear hit the same edge, set wins.
REQ-023 A COUNT write on an enabled cycle SHALL load WriteData exactly, with no increment that cycle; the match test uses the pre-edge COUNT.
REQ-024 Irq = |(STATUS[1:0] & IRQ_EN[1:0]), registered-source combinational output.
REQ-025 Unused upper register bits SHALL read 0.

Reset
REQ-026 Reset asserted low SHALL immediately force PortOut, STATUS, IRQ_EN, COUNT, COMPARE, CTRL and the synchronizer flops to 0; Irq=0.
REQ-027 Reset mid-count SHALL abandon the count; counting resumes only after software sets CTRL.bit0.
REQ-028 The first in_chg after reset SHALL NOT fire from synchronizer fill when PortIn is held at 0.

Structure
REQ-029 Register word indices, STATUS bit positions and the IO_BASE default SHALL live in a shared package used by this block and MIPS_Processor integration.
REQ-030 The synchronizer plus change detector SHALL be one sub-module, sync_edge_detect, parameterized by width.

Verification
REQ-031 Reset low, then store 32'hA5A5_0F0F to IO_BASE+0 -> PortOut=32'hA5A5_0F0F on the next edge; a load reads it back.
REQ-032 PortIn 8'h00→8'h3C -> PORT_IN reads 32'h3C two cycles later; STATUS=1 on the same cycle; W1C 1 → STATUS=0.
REQ-033 COMPARE=5, COUNT=0, CTRL=1, IRQ_EN=2 -> STATUS bit1 and Irq high after the 6th edge following enable.
REQ-034 COUNT=32'hFFFF_FFFE, enabled -> reads FFFF_FFFF then 0, then 1; no flag unless COMPARE matches.
REQ-035 W1C of bit0 on the same edge as a new PortIn change -> bit0 remains 1.
REQ-036 Address IO_BASE+32 or IO_BASE-4 with MemWrite -> Hit=0, no register changes; reset pulse mid-count -> all registers 0 asynchronously.
